// File: rtl/taiko_pkg.sv
// Screen geometry, pixel field widths and arbiter state encoding used by the
// drawing blocks and the pixel plot arbiter.
package taiko_pkg;

  localparam int SCR_W  = 160;
  localparam int SCR_H  = 120;
  localparam int X_W    = 8;
  localparam int Y_W    = 7;
  localparam int COL_W  = 3;
  localparam int BCNT_W = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first asserted request at or after ptr, searching
// cyclically through NUM_SRC requesters.
module rr_pick #(
  parameter int NUM_SRC = 4,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW-1:0] j;
  logic          found;

  // Walk from ptr with wrap-around; the first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = ptr;
    any   = |req;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found && req[j]) begin
        idx   = j;
        found = 1'b1;
      end
      j = (j == IW'(NUM_SRC - 1)) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_plot_arbiter.sv
// Merges several valid/ready pixel streams onto the single VGA adapter write
// port. One source owns the port for a whole burst; off-screen pixels are
// accepted but not plotted.
module pixel_plot_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 320,
  parameter int SCR_W     = taiko_pkg::SCR_W,
  parameter int SCR_H     = taiko_pkg::SCR_H
) (
  input  logic                                CLOCK_50,
  input  logic                                reset,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC-1:0]                  src_last,
  input  logic [taiko_pkg::X_W*NUM_SRC-1:0]   src_x,
  input  logic [taiko_pkg::Y_W*NUM_SRC-1:0]   src_y,
  input  logic [taiko_pkg::COL_W*NUM_SRC-1:0] src_color,
  output logic [NUM_SRC-1:0]                  src_ready,
  output logic [taiko_pkg::X_W-1:0]           x,
  output logic [taiko_pkg::Y_W-1:0]           y,
  output logic [taiko_pkg::COL_W-1:0]         colour,
  output logic                                plot,
  output logic                                busy
);
  import taiko_pkg::*;

  localparam int GW = $clog2(NUM_SRC);
  localparam logic [BCNT_W-1:0] MAX_B = BCNT_W'(MAX_BURST);
  localparam logic [X_W:0]      X_LIM = (X_W + 1)'(SCR_W);
  localparam logic [Y_W:0]      Y_LIM = (Y_W + 1)'(SCR_H);

  arb_state_t        state, state_n;
  logic [GW-1:0]     gnt, gnt_n, rr, rr_n, pick_idx;
  logic [BCNT_W-1:0] bcnt, bcnt_n, bcnt_inc;
  logic              pick_any, acc, in_scr;

  logic [X_W-1:0]   sel_x;
  logic [Y_W-1:0]   sel_y;
  logic [COL_W-1:0] sel_c;
  logic             sel_last;

  rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req (src_valid),
    .ptr (rr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Route the granted source's pixel fields.
  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_c    = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt == GW'(i)) begin
        sel_x    = src_x[i*X_W +: X_W];
        sel_y    = src_y[i*Y_W +: Y_W];
        sel_c    = src_color[i*COL_W +: COL_W];
        sel_last = src_last[i];
      end
    end
  end

  assign in_scr   = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  assign bcnt_inc = bcnt + 1'b1;
  assign busy     = (state == ST_BURST);

  // Next-state: grant on IDLE, count beats and release on last or burst cap.
  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    rr_n      = rr;
    bcnt_n    = bcnt;
    src_ready = '0;
    acc       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_n   = pick_idx;
          state_n = ST_BURST;
        end
      end
      ST_BURST: begin
        src_ready[gnt] = src_valid[gnt];
        acc            = src_valid[gnt];
        if (acc) begin
          if (sel_last || bcnt_inc == MAX_B) begin
            bcnt_n  = '0;
            rr_n    = (gnt == GW'(NUM_SRC - 1)) ? '0 : gnt + 1'b1;
            state_n = ST_IDLE;
          end else begin
            bcnt_n = bcnt_inc;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= ST_IDLE;
      gnt   <= '0;
      rr    <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      rr    <= rr_n;
      bcnt  <= bcnt_n;
    end
  end

  // Output register: capture on-screen accepted beats, strobe plot once.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      plot <= acc && in_scr;
      if (acc && in_scr) begin
        x      <= sel_x;
        y      <= sel_y;
        colour <= sel_c;
      end
    end
  end

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Directed bench for pixel_plot_arbiter with a transaction-level arbiter model.
module tb_pixel_plot_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 320;

  logic           CLOCK_50 = 1'b0;
  logic           reset    = 1'b1;
  logic [N-1:0]   src_valid, src_last, src_ready;
  logic [8*N-1:0] src_x;
  logic [7*N-1:0] src_y;
  logic [3*N-1:0] src_color;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           plot, busy;

  pixel_plot_arbiter #(.NUM_SRC(N), .MAX_BURST(MAXB), .SCR_W(160), .SCR_H(120)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .src_valid(src_valid), .src_last(src_last),
    .src_x(src_x), .src_y(src_y), .src_color(src_color), .src_ready(src_ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct { int x; int y; int c; bit last; int gap; int tag; } pix_t;
  pix_t q[N][$];

  // model state
  bit m_busy, ep;
  int m_gnt, m_rr, m_cnt, ex, ey, ec, acc_now, cyc, n_plot;
  int acc_src[$], acc_tag[$], acc_cyc[$], burst_src[$];
  int total, bad;
  bit chk_en;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    src_valid = '0; src_last = '0; src_x = '0; src_y = '0; src_color = '0;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        src_valid[i]       = (q[i][0].gap == 0);
        src_last[i]        = q[i][0].last;
        src_x[8*i +: 8]    = 8'(q[i][0].x);
        src_y[7*i +: 7]    = 7'(q[i][0].y);
        src_color[3*i +: 3] = 3'(q[i][0].c);
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] er;
    er = '0;
    if (m_busy && src_valid[m_gnt]) er[m_gnt] = 1'b1;
    check("src_ready", int'(src_ready), int'(er));
    check("busy", int'(busy), int'(m_busy));
    check("plot", int'(plot), int'(ep));
    check("x", int'(x), ex);
    check("y", int'(y), ey);
    check("colour", int'(colour), ec);
  endtask

  // Arbiter behaviour in terms of bursts, grants and accepted pixels.
  task automatic model_update();
    pix_t p;
    bit   found;
    acc_now = -1;
    if (reset) begin
      m_busy = 0; m_gnt = 0; m_rr = 0; m_cnt = 0;
      ex = 0; ey = 0; ec = 0; ep = 0;
    end else if (!m_busy) begin
      ep = 0;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && src_valid[(m_rr + k) % N]) begin
          m_gnt = (m_rr + k) % N;
          found = 1;
        end
      end
      if (found) begin
        m_busy = 1;
        burst_src.push_back(m_gnt);
      end
    end else if (src_valid[m_gnt]) begin
      p = q[m_gnt][0];
      acc_now = m_gnt;
      acc_src.push_back(m_gnt); acc_tag.push_back(p.tag); acc_cyc.push_back(cyc);
      m_cnt++;
      ep = (p.x < 160) && (p.y < 120);
      if (ep) begin
        ex = p.x; ey = p.y; ec = p.c; n_plot++;
      end
      if (p.last || m_cnt == MAXB) begin
        m_cnt = 0; m_rr = (m_gnt + 1) % N; m_busy = 0;
      end
    end else begin
      ep = 0;
    end
  endtask

  task automatic step();
    pix_t p;
    @(negedge CLOCK_50);
    if (chk_en) compare();
    model_update();
    @(posedge CLOCK_50);
    #1;
    cyc++;
    if (acc_now >= 0) void'(q[acc_now].pop_front());
    for (int i = 0; i < N; i++) begin
      if (i != acc_now && q[i].size() > 0 && q[i][0].gap > 0) begin
        p = q[i][0]; p.gap--; q[i][0] = p;
      end
    end
    drive_inputs();
  endtask

  task automatic run_drain(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin step(); n++; end
    if (n >= max) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d cycles want <%0d", n, max);
    end
    step(); step();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic push(input int s, input int px, input int py, input int pc,
                      input bit last, input int gap, input int tag);
    pix_t p;
    p.x = px; p.y = py; p.c = pc; p.last = last; p.gap = gap; p.tag = tag;
    q[s].push_back(p);
  endtask

  int p0, a0, b0, n;

  initial begin
    total = 0; bad = 0; chk_en = 0; cyc = 0; n_plot = 0;
    m_busy = 0; m_gnt = 0; m_rr = 0; m_cnt = 0; ex = 0; ey = 0; ec = 0; ep = 0;
    drive_inputs();
    do_reset();
    chk_en = 1;
    do_reset();

    // 320-beat digit burst from source 0
    p0 = n_plot;
    for (int k = 0; k < 320; k++) push(0, 139 + k % 20, k / 20, k % 8, k == 319, 0, k);
    run_drain(1000);
    check("t1_plots", n_plot - p0, 320);
    check("t1_last_x", int'(x), 158);
    check("t1_last_y", int'(y), 15);

    // Two sources, alternating 3-beat bursts
    do_reset();
    b0 = burst_src.size();
    for (int k = 0; k < 6; k++) begin
      push(0, 10 + k, 1, 1, (k % 3) == 2, 0, k);
      push(1, 40 + k, 2, 2, (k % 3) == 2, 0, 100 + k);
    end
    run_drain(100);
    check("t2_g0", burst_src[b0], 0);
    check("t2_g1", burst_src[b0 + 1], 1);
    check("t2_g2", burst_src[b0 + 2], 0);
    check("t2_g3", burst_src[b0 + 3], 1);

    // Clipping at screen edges
    p0 = n_plot; a0 = acc_src.size();
    push(0, 159, 119, 5, 0, 0, 0);
    push(0, 160, 5, 6, 0, 0, 1);
    push(0, 3, 120, 7, 1, 0, 2);
    run_drain(50);
    check("t3_plots", n_plot - p0, 1);
    check("t3_accepts", acc_src.size() - a0, 3);
    check("t3_x", int'(x), 159);
    check("t3_y", int'(y), 119);
    check("t3_colour", int'(colour), 5);

    // Forced release at MAX_BURST with a competing source
    do_reset();
    b0 = burst_src.size(); a0 = acc_src.size();
    for (int k = 0; k < 330; k++) push(2, k % 160, k / 160, k % 8, 0, 0, k);
    for (int k = 0; k < 4; k++) push(3, k, 50, 3, k == 3, 0, 1000 + k);
    run_drain(1000);
    check("t4_g0", burst_src[b0], 2);
    check("t4_g1", burst_src[b0 + 1], 3);
    check("t4_g2", burst_src[b0 + 2], 2);
    check("t4_beat320_src", acc_src[a0 + 320], 3);
    check("t4_beat320_tag", acc_tag[a0 + 320], 1000);
    check("t4_resume_src", acc_src[a0 + 324], 2);
    check("t4_resume_tag", acc_tag[a0 + 324], 320);

    // Source stalls for 5 cycles mid-burst
    do_reset();
    a0 = acc_src.size();
    for (int k = 0; k < 6; k++) push(1, 10 + k, 20, k % 8, k == 5, (k == 3) ? 5 : 0, k);
    run_drain(100);
    check("t5_beats", acc_src.size() - a0, 6);
    check("t5_span", acc_cyc[a0 + 5] - acc_cyc[a0], 10);

    // Reset in the middle of a burst
    a0 = acc_src.size();
    for (int k = 0; k < 20; k++) push(3, k, 60, k % 8, k == 19, 0, k);
    push(1, 100, 100, 4, 0, 3, 500);
    push(1, 101, 100, 4, 1, 0, 501);
    n = 0;
    while (acc_src.size() < a0 + 10 && n < 100) begin step(); n++; end
    check("t6_reach10", acc_src.size() - a0, 10);
    b0 = burst_src.size();
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_plot", int'(plot), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(src_ready), 0);
    check("t6_x", int'(x), 0);
    check("t6_y", int'(y), 0);
    check("t6_colour", int'(colour), 0);
    run_drain(200);
    check("t6_first_grant", burst_src[b0], 1);
    check("t6_resume_tag", acc_tag[a0 + 12], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
